// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: state encoding,
// default widths and the grant-index width helper.
package dmem_arb_pkg;

    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2
    } arb_state_e;

    // A single requester still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request-side and memory-side signals of the data-memory arbiter.
// The slave modport is the arbiter; master is the FP stages plus the memory macro.
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
);
    logic [NREQ-1:0]        REQ;
    logic [NREQ-1:0]        REQ_WE;
    logic [NREQ*ADDR_W-1:0] REQ_ADDR;
    logic [NREQ*DATA_W-1:0] REQ_WDATA;
    logic [NREQ-1:0]        ACK;
    logic [DATA_W-1:0]      RDATA;
    logic                   BUSY;
    logic                   MEM_EN;
    logic                   MEM_WE;
    logic [ADDR_W-1:0]      MEM_ADDR;
    logic [DATA_W-1:0]      MEM_WDATA;
    logic [DATA_W-1:0]      MEM_RDATA;

    modport slave (
        input  REQ, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_RDATA,
        output ACK, RDATA, BUSY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );

    modport master (
        output REQ, REQ_WE, REQ_ADDR, REQ_WDATA, MEM_RDATA,
        input  ACK, RDATA, BUSY, MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA
    );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational rotating picker: first eligible index at or after start_idx,
// wrapping modulo NREQ.
module dmem_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   start_idx,
    output logic [IW-1:0]   win_idx,
    output logic            win_vld
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, start_idx} + (IW+1)'(k);
            if (sum >= (IW+1)'(NREQ)) begin
                sum = sum - (IW+1)'(NREQ);
            end
            idx = sum[IW-1:0];
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one synchronous-read data memory between NREQ FP stages.
// DMEM_ARB_RR_EN defined: round-robin from LAST+1; undefined: lowest index wins.
//
// state | meaning
// IDLE  | waiting; picks a winner among REQ & ~ACK and latches its request
// ISSUE | MEM_EN high, memory performs the latched access at cycle end
// CAPT  | load data captured into RDATA, ACK pulse scheduled for the winner
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic          CLK,
    input  logic          MR_N,
    dmem_arbiter_if.slave bus
);

    localparam int IW = idx_w(NREQ);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [NREQ-1:0]   elig;
    logic [IW-1:0]     start_idx;
    logic [IW-1:0]     win_idx;
    logic              win_vld;

    // A requester still holding REQ during its ACK cycle must not win again.
    assign elig = bus.REQ & ~ack_q;

`ifdef DMEM_ARB_RR_EN
    logic [IW-1:0] last_q, last_d;

    always_comb begin
        if (last_q == IW'(NREQ-1)) begin
            start_idx = '0;
        end else begin
            start_idx = last_q + 1'b1;
        end
    end
`else
    assign start_idx = '0;
`endif

    dmem_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .elig      (elig),
        .start_idx (start_idx),
        .win_idx   (win_idx),
        .win_vld   (win_vld)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = '0;
        rdata_d = rdata_q;
`ifdef DMEM_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    grant_d = win_idx;
                    we_d    = bus.REQ_WE[win_idx];
                    addr_d  = bus.REQ_ADDR[int'(win_idx)*ADDR_W +: ADDR_W];
                    wdata_d = bus.REQ_WDATA[int'(win_idx)*DATA_W +: DATA_W];
`ifdef DMEM_ARB_RR_EN
                    last_d  = win_idx;
`endif
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = CAPT;
            end
            CAPT: begin
                if (!we_q) begin
                    rdata_d = bus.MEM_RDATA;
                end
                ack_d[grant_q] = 1'b1;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge MR_N) begin
        if (!MR_N) begin
            state_q <= IDLE;
            grant_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q  <= IW'(NREQ-1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Memory strobes decode from state so a reset during ISSUE drops them at once.
    assign bus.MEM_EN    = (state_q == ISSUE);
    assign bus.MEM_WE    = (state_q == ISSUE) && we_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.ACK       = ack_q;
    assign bus.RDATA     = rdata_q;
    assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural synchronous-read memory;
// expectations depend on whether DMEM_ARB_RR_EN is defined.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int NREQ   = 2;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;

    typedef struct {
        logic [NREQ-1:0]   ack;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    logic clk;
    logic mr_n;

    dmem_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    dmem_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLK  (clk),
        .MR_N (mr_n),
        .bus  (bus.slave)
    );

    logic [DATA_W-1:0] mem     [1 << ADDR_W];
    logic [DATA_W-1:0] ref_mem [1 << ADDR_W];
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] exp_rd;
    exp_t              sb_q[$];

    int n_chk;
    int n_bad;
    int en_cnt;
    int we_cnt;
    logic [ADDR_W-1:0] en_addr;
    logic [DATA_W-1:0] en_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.MEM_EN) begin
            if (bus.MEM_WE) begin
                mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
            end else begin
                mem_rdata <= mem[bus.MEM_ADDR];
            end
        end
    end
    assign bus.MEM_RDATA = mem_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Every ACK seen must match the next scoreboard entry in order.
    always @(negedge clk) begin
        if (bus.ACK !== '0) begin
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", 32'(bus.ACK), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_ack", 32'(bus.ACK), 32'(e.ack));
                chk("sb_rdata", 32'(bus.RDATA), 32'(e.rdata));
            end
        end
    end

    task automatic set_req(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
        bus.REQ_WE[idx]                    = we;
        bus.REQ_ADDR[idx*ADDR_W +: ADDR_W]  = addr;
        bus.REQ_WDATA[idx*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic push_exp(input int idx, input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata);
        exp_t e;
        if (we) begin
            ref_mem[addr] = wdata;
        end else begin
            exp_rd = ref_mem[addr];
        end
        e.ack   = NREQ'(1) << idx;
        e.rdata = exp_rd;
        sb_q.push_back(e);
    endtask

    task automatic wait_ack(input int idx, output int n);
        bit seen;
        seen   = 1'b0;
        n      = 0;
        en_cnt = 0;
        we_cnt = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.MEM_EN) begin
                en_cnt++;
                if (bus.MEM_WE) we_cnt++;
                en_addr  = bus.MEM_ADDR;
                en_wdata = bus.MEM_WDATA;
            end
            if (bus.ACK[idx]) seen = 1'b1;
        end
        if (!seen) chk("ack_timeout", 32'(idx), 32'hFFFF_FFFF);
    endtask

    task automatic drop_and_idle(input int idx);
        bus.REQ[idx] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int first;
        int second;
        n_chk = 0;
        n_bad = 0;
        exp_rd = '0;
        mem_rdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = DATA_W'(16'h5A00 ^ i);
            ref_mem[i] = DATA_W'(16'h5A00 ^ i);
        end

        // Reset held with both requests pending.
        mr_n          = 1'b0;
        bus.REQ       = '1;
        bus.REQ_WE    = '0;
        bus.REQ_ADDR  = '0;
        bus.REQ_WDATA = '0;
        set_req(0, 1'b0, 10'h020, 16'h0000);
        set_req(1, 1'b1, 10'h030, 16'h1234);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(bus.ACK), 32'h0);
        chk("rst_mem_en", 32'(bus.MEM_EN), 32'h0);
        chk("rst_rdata", 32'(bus.RDATA), 32'h0);
        chk("rst_busy", 32'(bus.BUSY), 32'h0);
        chk("rst_mem_addr", 32'(bus.MEM_ADDR), 32'h0);

        push_exp(0, 1'b0, 10'h020, 16'h0000);
        push_exp(1, 1'b1, 10'h030, 16'h1234);
        mr_n = 1'b1;
        wait_ack(0, n);
        chk("post_rst_lat0", 32'(n), 32'd3);
        bus.REQ[0] = 1'b0;
        wait_ack(1, n);
        chk("post_rst_lat1", 32'(n), 32'd3);
        chk("post_rst_st_addr", 32'(en_addr), 32'h030);
        drop_and_idle(1);

        // Single store then load on requester 0.
        set_req(0, 1'b1, 10'h005, 16'hBEEF);
        push_exp(0, 1'b1, 10'h005, 16'hBEEF);
        bus.REQ[0] = 1'b1;
        wait_ack(0, n);
        chk("st_lat", 32'(n), 32'd3);
        chk("st_en_cnt", 32'(en_cnt), 32'd1);
        chk("st_we_cnt", 32'(we_cnt), 32'd1);
        chk("st_addr", 32'(en_addr), 32'h005);
        chk("st_wdata", 32'(en_wdata), 32'hBEEF);
        drop_and_idle(0);
        chk("st_mem_we_idle", 32'(bus.MEM_WE), 32'h0);

        set_req(0, 1'b0, 10'h005, 16'h0000);
        push_exp(0, 1'b0, 10'h005, 16'h0000);
        bus.REQ[0] = 1'b1;
        wait_ack(0, n);
        chk("ld_lat", 32'(n), 32'd3);
        chk("ld_en_cnt", 32'(en_cnt), 32'd1);
        chk("ld_we_cnt", 32'(we_cnt), 32'd0);
        chk("ld_beef", 32'(bus.RDATA), 32'hBEEF);
        drop_and_idle(0);

        // Both raised from idle after a grant to 0: arbitration policy decides order.
        set_req(0, 1'b1, 10'h100, 16'hA5A5);
        set_req(1, 1'b0, 10'h100, 16'h0000);
`ifdef DMEM_ARB_RR_EN
        first  = 1;
        second = 0;
`else
        first  = 0;
        second = 1;
`endif
        push_exp(first, (first == 0), 10'h100, 16'hA5A5);
        push_exp(second, (second == 0), 10'h100, 16'hA5A5);
        bus.REQ = '1;
        wait_ack(first, n);
        chk("cont_lat_first", 32'(n), 32'd3);
        bus.REQ[first] = 1'b0;
        wait_ack(second, n);
        chk("cont_lat_second", 32'(n), 32'd3);
        drop_and_idle(second);

        // Requester 1 holds REQ through its ACK cycle; it must not be re-granted.
        set_req(1, 1'b0, 10'h040, 16'h0000);
        push_exp(1, 1'b0, 10'h040, 16'h0000);
        bus.REQ[1] = 1'b1;
        wait_ack(1, n);
        chk("mask_lat", 32'(n), 32'd3);
        @(posedge clk);
        #1;
        chk("mask_busy", 32'(bus.BUSY), 32'h0);
        drop_and_idle(1);
        chk("mask_busy_after", 32'(bus.BUSY), 32'h0);

        // Withdraw and scramble the request after grant.
        set_req(0, 1'b0, 10'h010, 16'h0000);
        push_exp(0, 1'b0, 10'h010, 16'h0000);
        bus.REQ[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("wd_issue_en", 32'(bus.MEM_EN), 32'h1);
        bus.REQ[0] = 1'b0;
        set_req(0, 1'b1, 10'h3FF, 16'hFFFF);
        wait_ack(0, n);
        chk("wd_lat", 32'(n), 32'd2);
        chk("wd_rdata", 32'(bus.RDATA), 32'(ref_mem[10'h010]));
        @(posedge clk);
        #1;

        // Reset during CAPT of a load abandons it.
        set_req(1, 1'b0, 10'h011, 16'h0000);
        bus.REQ[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("capt_busy", 32'(bus.BUSY), 32'h1);
        mr_n       = 1'b0;
        bus.REQ[1] = 1'b0;
        exp_rd     = '0;
        #1;
        chk("mid_rst_rdata", 32'(bus.RDATA), 32'h0);
        chk("mid_rst_busy", 32'(bus.BUSY), 32'h0);
        chk("mid_rst_en", 32'(bus.MEM_EN), 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("mid_rst_ack", 32'(bus.ACK), 32'h0);
        end
        mr_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_mid_ack", 32'(bus.ACK), 32'h0);

        push_exp(1, 1'b0, 10'h011, 16'h0000);
        bus.REQ[1] = 1'b1;
        wait_ack(1, n);
        chk("post_mid_lat", 32'(n), 32'd3);
        drop_and_idle(1);
        repeat (3) @(posedge clk);
        #1;

        chk("sb_left", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port, synchronous-read data memory between NREQ Function Processing stages.
- Each FP stage raises a load (LDM) or store (STM) request; the address is the stage's ALU result and the write data is its DataL.
- The block grants one requester at a time, sequences the memory access and returns the ACK and the load data.
- It sits between the FP stages' LOAD_FLG/WRITE_EN outputs and the data memory macro.

Parameters:
- NREQ, 2, number of requesting FP stages (2..8).
- DATA_W, 16, data word width; matches the packet data field.
- ADDR_W, 10, data memory address width; the low ADDR_W bits of the ALU result are used.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- MR_N  in  1  master reset, asynchronous, active-low.
- REQ  in  NREQ  per-requester request; level, held until that requester's ACK.
- REQ_WE  in  NREQ  1 = store, 0 = load; valid while REQ is high.
- REQ_ADDR  in  NREQ*ADDR_W  packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- REQ_WDATA  in  NREQ*DATA_W  packed store data, same packing as REQ_ADDR.
- ACK  out  NREQ  one-cycle completion pulse, one-hot.
- RDATA  out  DATA_W  load result; valid in the ACK cycle of a load.
- BUSY  out  1  high whenever the state is not IDLE.
- MEM_EN  out  1  memory enable.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_RDATA  in  DATA_W  memory read data; valid one cycle after the MEM_EN cycle.

Behaviour:
- Reset (MR_N low, asynchronous):
  - state = IDLE; ACK = 0; RDATA = 0; BUSY = 0; MEM_EN = 0; MEM_WE = 0; MEM_ADDR = 0; MEM_WDATA = 0.
  - grant register = 0; LAST pointer = NREQ-1.
- FSM has three states: IDLE, ISSUE, CAPT.
- IDLE:
  - Eligible set = REQ & ~ACK. A requester whose ACK is high this cycle is masked, so a still-held REQ is not re-granted.
  - If the eligible set is non-empty: pick the winner by round-robin. Search starts at LAST+1 mod NREQ, first eligible index wins.
  - Latch winner index, REQ_WE, REQ_ADDR and REQ_WDATA into registers; set LAST = winner; go to ISSUE.
  - If the eligible set is empty, stay in IDLE.
- ISSUE:
  - MEM_EN = 1; MEM_WE, MEM_ADDR and MEM_WDATA are driven from the latched registers.
  - The memory performs the access at the end of this cycle. Next state is CAPT.
- CAPT:
  - MEM_EN = 0.
  - If the access is a load, RDATA <= MEM_RDATA at the end of the cycle. If it is a store, RDATA holds its previous value.
  - ACK[grant] <= 1 at the end of the cycle; next state is IDLE.
- ACK is high for exactly one cycle (the IDLE cycle after CAPT) and is cleared on the following edge.
- Latency from REQ sampled high in IDLE to the ACK cycle is 3 cycles; peak throughput is one access per 3 cycles.
- A new grant may be made in the same cycle ACK is high, to a different requester.
- Outside ISSUE, MEM_EN = 0 and MEM_WE = 0. MEM_ADDR and MEM_WDATA hold the last latched values.
- REQ deasserted before grant: the request is simply not seen.
- REQ deasserted after grant: the access still completes and ACK still pulses.
- REQ_WE, REQ_ADDR and REQ_WDATA changing after grant have no effect.
- Reset during ISSUE: MEM_EN drops immediately because it is decoded from state. Whether the write happened is undefined; no ACK is issued.
- Reset during CAPT: the access is abandoned and no ACK is issued.
- REQ bits beyond NREQ do not exist; widths are exact.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration with the LAST pointer, as described above.
- Undefined: fixed priority, lowest index wins. The LAST register is not implemented; all other timing is identical.

Decomposition:
- Package dmem_arb_pkg holds:
  - state encoding constants: IDLE=2'd0, ISSUE=2'd1, CAPT=2'd2;
  - default DATA_W and ADDR_W;
  - a function for the index width, clog2(NREQ).
- Sub-module dmem_rr_pick: combinational. Inputs are the eligible vector and the start index; outputs are the winner index and a valid bit. Under fixed priority the start index is tied to 0.

Test Plan:
- Reset: hold MR_N low with REQ=2'b11 -> ACK=0, MEM_EN=0, RDATA=0, BUSY=0. After release, first grant goes to requester 0.
- Single store, then load: req0 stores WE=1, ADDR=0x005, WDATA=0xBEEF -> MEM_EN/MEM_WE high one cycle with addr 0x005, ACK=2'b01 three cycles later. Then req0 loads 0x005 -> RDATA=0xBEEF in its ACK cycle.
- Contention: REQ=2'b11 held continuously, each requester dropping REQ on its ACK -> grants alternate 0,1. With DMEM_ARB_RR_EN undefined and REQ held again after its ACK, req0 wins every time.
- ACK masking: req1 holds REQ one cycle past its ACK while req0 is idle -> no second grant to req1; BUSY stays 0 that cycle.
- Withdraw after grant: req0 drops REQ during ISSUE of a load from 0x010 -> ACK[0] still pulses and RDATA = mem[0x010].
- Mid-operation reset: assert MR_N low during CAPT of a load -> ACK never pulses, RDATA=0, state IDLE. A subsequent request completes normally in 3 cycles.
